// File: rtl/impulse_counter_pkg.sv
// impulse_counter_pkg: shared FSM/edge-mode types and address-width helper
package impulse_counter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;
  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10,
    EM_HALT = 2'b11
  } edge_mode_e;
  function automatic int addr_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/impulse_counter_multi_ch_counter.sv
// ch_counter: synchronizer, edge detector and saturating counter with sticky overflow for one channel
module ch_counter
  import impulse_counter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in,
  input  logic [1:0]       i_mode,
  input  logic             i_snap,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf;
  logic                   w_rise, w_fall, w_inc, w_sat;
  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_fall = ~r_sync[SYNC_STAGES-1] & r_prev;
  assign w_sat  = &r_cnt;
  always_comb
    w_inc = (i_mode == EM_RISE) ? w_rise :
            (i_mode == EM_FALL) ? w_fall :
            (i_mode == EM_BOTH) ? (w_rise | w_fall) : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  // an edge in the snapshot cycle opens the new window with a count of one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_snap) begin
      r_cnt <= {{(CNT_W-1){1'b0}}, w_inc};
      r_ovf <= 1'b0;
    end else if (w_inc) begin
      r_cnt <= w_sat ? r_cnt : r_cnt + 1'b1;
      r_ovf <= r_ovf | w_sat;
    end
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/impulse_counter_multi.sv
// impulse_counter_multi: multi-channel gated impulse counter with serial frame readout per rtc window
module impulse_counter_multi
  import impulse_counter_pkg::*;
#(
  parameter  int NUM_CH      = 8,
  parameter  int CNT_W       = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = addr_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              rtc_in,
  input  logic [1:0]        edge_mode,
  output logic              serial_out,
  output logic              sl_out,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ovf_global,
  output logic              ovf_rtc,
  output logic              busy
);
  localparam int BIT_W = $clog2(CNT_W + 1);
  state_e                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_rtc_sync;
  logic                   r_rtc_prev;
  logic                   w_rtc_rise, w_snap, w_last_bit, w_last_ch;
  logic [CNT_W-1:0]       w_live_cnt [NUM_CH];
  logic [NUM_CH-1:0]      w_live_ovf;
  logic [CNT_W-1:0]       r_shd_cnt [NUM_CH];
  logic [NUM_CH-1:0]      r_shd_ovf;
  logic [CNT_W:0]         r_sh;
  logic [ADDR_W-1:0]      r_addr;
  logic [BIT_W-1:0]       r_bit;
  logic                   r_ovf_global, r_ovf_rtc;
  assign w_rtc_rise = r_rtc_sync[SYNC_STAGES-1] & ~r_rtc_prev;
  assign w_snap     = w_rtc_rise & (r_state == ST_IDLE);
  assign w_last_bit = r_bit == BIT_W'(CNT_W);
  assign w_last_ch  = r_addr == ADDR_W'(NUM_CH - 1);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_in  (ch_in[i]),
      .i_mode(edge_mode),
      .i_snap(w_snap),
      .o_cnt (w_live_cnt[i]),
      .o_ovf (w_live_ovf[i])
    );
  end
  // rtc ticks arriving mid-frame are dropped but remembered until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rtc_sync <= '0;
      r_rtc_prev <= 1'b0;
      r_ovf_rtc  <= 1'b0;
    end else begin
      r_rtc_sync <= {r_rtc_sync[SYNC_STAGES-2:0], rtc_in};
      r_rtc_prev <= r_rtc_sync[SYNC_STAGES-1];
      r_ovf_rtc  <= r_ovf_rtc | (w_rtc_rise & (r_state != ST_IDLE));
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shd_cnt    <= '{default: '0};
      r_shd_ovf    <= '0;
      r_ovf_global <= 1'b0;
    end else if (w_snap) begin
      r_shd_cnt    <= w_live_cnt;
      r_shd_ovf    <= w_live_ovf;
      r_ovf_global <= |w_live_ovf;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == ST_IDLE) ? (w_rtc_rise ? ST_LOAD : ST_IDLE) :
             (r_state == ST_LOAD) ? ST_SHIFT :
             !w_last_bit ? ST_SHIFT :
             w_last_ch ? ST_IDLE : ST_LOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sh   <= '0;
      r_bit  <= '0;
      r_addr <= '0;
    end else begin
      r_sh   <= (r_state == ST_LOAD)  ? {r_shd_ovf[r_addr], r_shd_cnt[r_addr]} :
                (r_state == ST_SHIFT) ? {r_sh[CNT_W-1:0], 1'b0} : r_sh;
      r_bit  <= (r_state == ST_SHIFT) ? r_bit + 1'b1 : '0;
      r_addr <= (r_state == ST_SHIFT && w_last_bit) ? (w_last_ch ? '0 : r_addr + 1'b1) : r_addr;
    end
  always_comb begin
    serial_out = (r_state == ST_SHIFT) & r_sh[CNT_W];
    sl_out     = r_state == ST_LOAD;
    busy       = r_state != ST_IDLE;
    ch_addr    = (r_state == ST_IDLE) ? '0 : r_addr;
  end
  assign ovf_global = r_ovf_global;
  assign ovf_rtc    = r_ovf_rtc;
endmodule

// File: tb/tb_impulse_counter_multi.sv
// tb_impulse_counter_multi: table-driven windows plus hand sequences; frame words checked via a scoreboard queue
module tb_impulse_counter_multi;
  logic       clk = 1'b0, rst_n = 1'b0, rtc_in = 1'b0;
  logic [3:0] ch_in = '0;
  logic [1:0] edge_mode = 2'b00;
  logic       serial_out, sl_out, ovf_global, ovf_rtc, busy;
  logic [1:0] ch_addr;
  int         n_chk = 0, n_err = 0;
  logic [8:0] exp_q[$];
  typedef struct packed {
    logic [1:0]      mode;
    logic [3:0][8:0] p;
    logic [3:0][8:0] w;
    logic            ovfg;
  } vec_t;
  vec_t vecs[7];
  always #5 clk = ~clk;
  impulse_counter_multi #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_in     (ch_in),
    .rtc_in    (rtc_in),
    .edge_mode (edge_mode),
    .serial_out(serial_out),
    .sl_out    (sl_out),
    .ch_addr   (ch_addr),
    .ovf_global(ovf_global),
    .ovf_rtc   (ovf_rtc),
    .busy      (busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      ch_in[c] = 1'b1;
      cyc(3);
      ch_in[c] = 1'b0;
      cyc(3);
    end
  endtask
  task automatic push4(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c, input logic [8:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_serial"}, serial_out, 0);
    chk({tag, "_sl"}, sl_out, 0);
    chk({tag, "_addr"}, ch_addr, 0);
    chk({tag, "_ovfg"}, ovf_global, 0);
    chk({tag, "_ovfrtc"}, ovf_rtc, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic get_frame();
    int t = 0;
    logic [8:0] w, e;
    logic sl_extra;
    @(negedge clk);
    while (!sl_out && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("frame_start", sl_out, 1);
    if (!sl_out) return;
    for (int c = 0; c < 4; c++) begin
      chk("sl_load", sl_out, 1);
      chk("addr_load", ch_addr, c);
      chk("busy_load", busy, 1);
      chk("serial_load", serial_out, 0);
      w = '0;
      sl_extra = 1'b0;
      for (int b = 0; b < 9; b++) begin
        @(negedge clk);
        w = {w[7:0], serial_out};
        sl_extra |= sl_out;
      end
      chk("sl_in_shift", sl_extra, 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
      chk($sformatf("word%0d", c), w, e);
      @(negedge clk);
    end
    chk("busy_end", busy, 0);
    chk("addr_idle", ch_addr, 0);
  endtask
  task automatic window(input logic ovfg);
    rtc_in = 1'b1;
    get_frame();
    chk("ovf_global", ovf_global, ovfg);
    rtc_in = 1'b0;
    cyc(3);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, quiet;
    vecs[0] = '{mode: 2'b00, p: {9'd0, 9'd3, 9'd0, 9'd5},   w: {9'h000, 9'h003, 9'h000, 9'h005}, ovfg: 1'b0};
    vecs[1] = '{mode: 2'b10, p: {9'd0, 9'd0, 9'd4, 9'd0},   w: {9'h000, 9'h000, 9'h008, 9'h000}, ovfg: 1'b0};
    vecs[2] = '{mode: 2'b01, p: {9'd1, 9'd0, 9'd0, 9'd2},   w: {9'h001, 9'h000, 9'h000, 9'h002}, ovfg: 1'b0};
    vecs[3] = '{mode: 2'b11, p: {9'd3, 9'd3, 9'd3, 9'd3},   w: {9'h000, 9'h000, 9'h000, 9'h000}, ovfg: 1'b0};
    vecs[4] = '{mode: 2'b00, p: {9'd300, 9'd0, 9'd0, 9'd0}, w: {9'h1FF, 9'h000, 9'h000, 9'h000}, ovfg: 1'b1};
    vecs[5] = '{mode: 2'b00, p: {9'd0, 9'd0, 9'd0, 9'd0},   w: {9'h000, 9'h000, 9'h000, 9'h000}, ovfg: 1'b0};
    vecs[6] = '{mode: 2'b10, p: {9'd3, 9'd0, 9'd2, 9'd1},   w: {9'h006, 9'h000, 9'h004, 9'h002}, ovfg: 1'b0};
    #1;
    chk_quiet("in_reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    chk_quiet("after_reset");
    for (int v = 0; v < 7; v++) begin
      edge_mode = vecs[v].mode;
      cyc(3);
      for (int c = 0; c < 4; c++) pulse(c, int'(vecs[v].p[c]));
      for (int c = 0; c < 4; c++) exp_q.push_back(vecs[v].w[c]);
      window(vecs[v].ovfg);
    end
    // second rtc tick 20 cycles into a frame is dropped; its window carries over
    edge_mode = 2'b00;
    cyc(3);
    pulse(0, 2);
    push4(9'h002, 9'h000, 9'h000, 9'h000);
    rtc_in = 1'b1;
    fork
      get_frame();
      begin
        pulse(1, 3);
        rtc_in = 1'b0;
        cyc(2);
        rtc_in = 1'b1;
      end
    join
    chk("ovf_rtc_set", ovf_rtc, 1);
    rtc_in = 1'b0;
    cyc(3);
    pulse(2, 1);
    push4(9'h000, 9'h003, 9'h001, 9'h000);
    window(1'b0);
    chk("ovf_rtc_sticky", ovf_rtc, 1);
    // ch0 edge coinciding with the snapshot lands in the next window
    pulse(3, 2);
    push4(9'h000, 9'h000, 9'h000, 9'h002);
    ch_in[0] = 1'b1;
    rtc_in   = 1'b1;
    get_frame();
    ch_in[0] = 1'b0;
    rtc_in   = 1'b0;
    cyc(3);
    push4(9'h001, 9'h000, 9'h000, 9'h000);
    window(1'b0);
    // reset during the SHIFT of channel 2
    pulse(0, 3);
    pulse(2, 4);
    rtc_in = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(sl_out && ch_addr == 2'd2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_ch2", ch_addr, 2);
    repeat (3) @(negedge clk);
    chk("busy_mid_shift", busy, 1);
    rst_n  = 1'b0;
    rtc_in = 1'b0;
    #1;
    chk_quiet("mid_reset");
    repeat (3) @(negedge clk);
    chk_quiet("mid_reset_hold");
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      quiet += int'(sl_out | busy | serial_out);
    end
    chk("no_frame_after_reset", quiet, 0);
    chk("ovf_rtc_cleared", ovf_rtc, 0);
    cyc(1);
    pulse(1, 1);
    push4(9'h000, 9'h001, 9'h000, 9'h000);
    window(1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
